// File: rtl/marquee_pkg.sv
// Shared constants and helpers for the scrolling seven-segment marquee.
// Segment patterns are active-low; the message ring is MSG_LEN slots deep.
package marquee_pkg;

   localparam int unsigned MSG_LEN = 6;
   localparam int unsigned SLOT_W  = 3;
   localparam int unsigned SUM_W   = SLOT_W + 1;
   localparam int unsigned SEG_W   = 8;
   localparam int unsigned DIG_N   = 4;

   localparam logic [SEG_W-1:0] SS_N     = 8'hD5;
   localparam logic [SEG_W-1:0] SS_T     = 8'hE1;
   localparam logic [SEG_W-1:0] SS_H     = 8'h91;
   localparam logic [SEG_W-1:0] SS_U     = 8'h83;
   localparam logic [SEG_W-1:0] SS_E     = 8'h61;
   localparam logic [SEG_W-1:0] SS_BLANK = 8'hFF;

   // Power-on message "NTHUEE"
   function automatic logic [SEG_W-1:0] init_slot(input logic [SLOT_W-1:0] s);
      case (s)
         3'd0:    return SS_N;
         3'd1:    return SS_T;
         3'd2:    return SS_H;
         3'd3:    return SS_U;
         default: return SS_E;
      endcase
   endfunction

   // (base + off) mod MSG_LEN for base in 0..MSG_LEN-1, off in 0..3
   function automatic logic [SLOT_W-1:0] slot_add(input logic [SLOT_W-1:0] base,
                                                  input logic [1:0]        off);
      logic [SUM_W-1:0] sum;
      sum = {1'b0, base} + {2'b00, off};
      if (sum >= SUM_W'(MSG_LEN)) sum = sum - SUM_W'(MSG_LEN);
      return sum[SLOT_W-1:0];
   endfunction

endpackage

// File: rtl/marquee_scan.sv
// Digit multiplexer: advances the scan index every DIV_SCAN cycles and
// drives the registered one-cold digit enable for the current index.
module marquee_scan
   import marquee_pkg::*;
#(
   parameter int unsigned DIV_SCAN = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [1:0]       idx,
   output logic [DIG_N-1:0] bit_dsp
);

   localparam int unsigned CW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == CW'(DIV_SCAN - 1));

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         cnt     <= '0;
         idx     <= '0;
         bit_dsp <= '1;
      end else begin
         cnt     <= wrap ? '0 : cnt + CW'(1);
         if (wrap) idx <= idx + 2'd1;
         bit_dsp <= ~(DIG_N'(1) << idx);
      end
   end

endmodule

// File: rtl/marquee_ctl.sv
// Scrolling marquee controller: 6-slot message ring, scroll head, write port
// and registered segment drive. Define MARQUEE_BLINK_EN to blink while paused.
module marquee_ctl
   import marquee_pkg::*;
#(
   parameter int unsigned DIV_SCROLL = 25000000,
   parameter int unsigned DIV_SCAN   = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pause,
   input  logic              dir,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [SLOT_W-1:0] wr_addr,
   input  logic [SEG_W-1:0]  wr_data,
   output logic [SEG_W-1:0]  BCD_dsp,
   output logic [DIG_N-1:0]  bit_dsp,
   output logic [SLOT_W-1:0] head,
   output logic              scroll_tick
);

   localparam int unsigned      SCW       = (DIV_SCROLL > 1) ? $clog2(DIV_SCROLL) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MSG_LEN - 1);

   logic [SCW-1:0]    scroll_cnt;
   logic              cnt_last;
   logic              cnt_run;
   logic              blank_c;
   logic              wr_fire;
   logic [1:0]        scan_idx;
   logic [SLOT_W-1:0] head_nxt;
   logic [SLOT_W-1:0] shown_slot;
   logic [SEG_W-1:0]  ring [MSG_LEN];

   assign cnt_last    = (scroll_cnt == SCW'(DIV_SCROLL - 1));
   assign scroll_tick = cnt_last && !pause;
   assign wr_ready    = !scroll_tick;
   assign wr_fire     = wr_valid && wr_ready && (wr_addr < SLOT_W'(MSG_LEN));
   assign shown_slot  = slot_add(head, 2'd3 - scan_idx);

`ifdef MARQUEE_BLINK_EN
   logic blank;

   // Counter keeps running while paused so it can pace the blink phase
   assign cnt_run = 1'b1;
   assign blank_c = blank && pause;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n)         blank <= 1'b0;
      else if (!pause)   blank <= 1'b0;
      else if (cnt_last) blank <= !blank;
   end
`else
   assign cnt_run = !pause;
   assign blank_c = 1'b0;
`endif

   always_comb begin
      head_nxt = head;
      if (dir) head_nxt = (head == '0)        ? LAST_SLOT : head - SLOT_W'(1);
      else     head_nxt = (head == LAST_SLOT) ? '0        : head + SLOT_W'(1);
   end

   // Scroll pacing; head only moves on the edge that closes a tick cycle
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         scroll_cnt <= '0;
         head       <= '0;
      end else begin
         if (cnt_run)     scroll_cnt <= cnt_last ? '0 : scroll_cnt + SCW'(1);
         if (scroll_tick) head       <= head_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < MSG_LEN; i++) ring[i] <= init_slot(SLOT_W'(i));
      end else if (wr_fire) begin
         ring[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) BCD_dsp <= SS_BLANK;
      else       BCD_dsp <= blank_c ? SS_BLANK : ring[shown_slot];
   end

   marquee_scan #(
      .DIV_SCAN (DIV_SCAN)
   ) u_scan (
      .clk     (clk),
      .rst_n   (rst_n),
      .idx     (scan_idx),
      .bit_dsp (bit_dsp)
   );

endmodule

// File: tb/tb_marquee_ctl.sv
// Randomised bench for marquee_ctl with a cycle-level behavioural model and
// a per-cycle compare process, plus literal pins on the directed scenarios.
module tb_marquee_ctl;

   localparam int DIV_SCROLL = 4;
   localparam int DIV_SCAN   = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pause, dir, wr_valid, wr_ready, scroll_tick;
   logic [2:0] wr_addr, head;
   logic [7:0] wr_data, BCD_dsp;
   logic [3:0] bit_dsp;

   int n_tests = 0;
   int n_fail  = 0;

   marquee_ctl #(.DIV_SCROLL(DIV_SCROLL), .DIV_SCAN(DIV_SCAN)) dut (
      .clk(clk), .rst_n(rst_n), .pause(pause), .dir(dir),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .BCD_dsp(BCD_dsp), .bit_dsp(bit_dsp), .head(head), .scroll_tick(scroll_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_pos;      // scroll count position within a DIV_SCROLL period
   int         m_head;
   int         m_scan;     // clocks since reset, drives the scan index
   int         m_wraps;    // completed periods since pause went high
   logic [7:0] m_ring [6];
   logic [7:0] e_bcd;
   logic [3:0] e_bit;

   always @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         m_pos = 0; m_head = 0; m_scan = 0; m_wraps = 0;
         m_ring[0] = 8'hD5; m_ring[1] = 8'hE1; m_ring[2] = 8'h91;
         m_ring[3] = 8'h83; m_ring[4] = 8'h61; m_ring[5] = 8'h61;
         e_bcd = 8'hFF; e_bit = 4'hF;
      end else begin
         int   idx, slot;
         logic tk, blank;
         idx   = (m_scan / DIV_SCAN) % 4;
         slot  = (m_head + 3 - idx) % 6;
         blank = 1'b0;
`ifdef MARQUEE_BLINK_EN
         blank = pause && (m_wraps % 2 == 1);
`endif
         e_bcd = blank ? 8'hFF : m_ring[slot];
         e_bit = ~(4'b0001 << idx);
         tk    = (m_pos == DIV_SCROLL - 1) && !pause;
         if (wr_valid && !tk && wr_addr < 3'd6) m_ring[wr_addr] = wr_data;
         if (tk) m_head = dir ? (m_head + 5) % 6 : (m_head + 1) % 6;
`ifdef MARQUEE_BLINK_EN
         if (!pause) m_wraps = 0;
         else if (m_pos == DIV_SCROLL - 1) m_wraps++;
         m_pos = (m_pos + 1) % DIV_SCROLL;
`else
         if (!pause) m_pos = (m_pos + 1) % DIV_SCROLL;
`endif
         m_scan++;
      end
   end

   // Compare every cycle on the falling edge
   always @(negedge clk) begin
      logic [7:0] xb; logic [3:0] xd; logic [2:0] xh; logic xt;
      if (rst_n) begin
         xb = 8'hFF; xd = 4'hF; xh = 3'd0; xt = 1'b0;
      end else begin
         xb = e_bcd; xd = e_bit; xh = 3'(m_head);
         xt = (m_pos == DIV_SCROLL - 1) && !pause;
      end
      check("BCD_dsp", 32'(BCD_dsp), 32'(xb));
      check("bit_dsp", 32'(bit_dsp), 32'(xd));
      check("head", 32'(head), 32'(xh));
      check("scroll_tick", 32'(scroll_tick), 32'(xt));
      check("wr_ready", 32'(wr_ready), 32'(!xt));
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk); #2;
   endtask

   task automatic smp();
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b1;
      cyc(); cyc();
      rst_n = 1'b0;
   endtask

   // With head frozen at 0, each digit must show the reset message
   task automatic pin_scan();
      logic [7:0] want [4];
      want[0] = 8'h83; want[1] = 8'h91; want[2] = 8'hE1; want[3] = 8'hD5;
      for (int d = 0; d < 4; d++) begin
         logic       ok;
         logic [3:0] en;
         ok = 1'b0;
         en = ~(4'b0001 << d);
         for (int i = 0; i < 12 && !ok; i++) begin
            smp();
            if (bit_dsp == en) ok = 1'b1;
            else cyc();
         end
         check("scan_found", 32'(ok), 32'd1);
         check("scan_digit", 32'(BCD_dsp), 32'(want[d]));
      end
      check("scan_head", 32'(head), 32'd0);
   endtask

   initial begin
      int ticks;
      logic seen;
      rst_n = 1'b1; pause = 1'b0; dir = 1'b0;
      wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
      repeat (3) cyc();

      // Reset release, display frozen for a full scan
`ifndef MARQUEE_BLINK_EN
      pause = 1'b1;
      rst_n = 1'b0;
      pin_scan();
`endif

      // Left scroll: 24 cycles -> 6 ticks, back to slot 0
      pulse_reset();
      pause = 1'b0; dir = 1'b0; ticks = 0;
      for (int i = 0; i < 24; i++) begin
         smp(); if (scroll_tick) ticks++;
         cyc();
      end
      smp();
      check("left_ticks", 32'(ticks), 32'd6);
      check("left_head", 32'(head), 32'd0);

      // Right scroll: 0 -> 5 -> 4
      dir = 1'b1; ticks = 0;
      for (int i = 0; i < 4; i++) begin smp(); if (scroll_tick) ticks++; cyc(); end
      smp();
      check("right_head1", 32'(head), 32'd5);
      for (int i = 0; i < 4; i++) begin smp(); if (scroll_tick) ticks++; cyc(); end
      smp();
      check("right_head2", 32'(head), 32'd4);
      check("right_ticks", 32'(ticks), 32'd2);

      // Pause with the count held at 2
      dir = 1'b0;
      cyc(); cyc();
      pause = 1'b1; ticks = 0;
      for (int i = 0; i < 20; i++) begin smp(); if (scroll_tick) ticks++; cyc(); end
      smp();
      check("pause_ticks", 32'(ticks), 32'd0);
      check("pause_head", 32'(head), 32'd4);
      cyc();
      pause = 1'b0;
      smp();
      check("resume_tick0", 32'(scroll_tick), 32'd0);
      cyc(); smp();
      check("resume_tick1", 32'(scroll_tick), 32'd1);
      check("collide_ready", 32'(wr_ready), 32'd0);

      // Write raised in the tick cycle must land one cycle later
      dir = 1'b1; wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'h03;
      cyc(); smp();
      check("collide_ready_next", 32'(wr_ready), 32'd1);
      check("collide_head", 32'(head), 32'd3);
      cyc();
      wr_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin smp(); if (BCD_dsp == 8'h03) seen = 1'b1; cyc(); end
      check("slot3_shown", 32'(seen), 32'd1);

      // Out-of-range slot is accepted and dropped
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         smp();
         if (wr_ready) seen = 1'b1; else cyc();
      end
      check("addr7_ready", 32'(seen), 32'd1);
      wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 8'h00;
      cyc();
      wr_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 24; i++) begin smp(); if (BCD_dsp == 8'h00) seen = 1'b1; cyc(); end
      check("addr7_dropped", 32'(seen), 32'd0);

`ifdef MARQUEE_BLINK_EN
      begin
         int nb, nv;
         pause = 1'b1; nb = 0; nv = 0;
         for (int i = 0; i < 16; i++) begin
            smp(); if (BCD_dsp == 8'hFF) nb++; else nv++;
            cyc();
         end
         check("blink_blank", 32'(nb > 0), 32'd1);
         check("blink_visible", 32'(nv > 0), 32'd1);
         pause = 1'b0;
      end
`endif

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) == 0) pause = ~pause;
         if ($urandom_range(0, 7) == 0) dir = ~dir;
         wr_valid = ($urandom_range(0, 3) == 0);
         wr_addr  = 3'($urandom_range(0, 7));
         wr_data  = 8'($urandom);
         rst_n    = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst_n = 1'b0; wr_valid = 1'b0; pause = 1'b0;
      repeat (4) cyc();

      // Reset mid-scroll with a write pending
      wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 8'h00;
      rst_n = 1'b1;
      cyc();
      wr_valid = 1'b0;
      smp();
      check("midrst_head", 32'(head), 32'd0);
      check("midrst_bcd", 32'(BCD_dsp), 32'hFF);
`ifndef MARQUEE_BLINK_EN
      pause = 1'b1;
      cyc();
      rst_n = 1'b0;
      pin_scan();
`else
      cyc();
      rst_n = 1'b0;
`endif
      repeat (4) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

endmodule
